tick_rate_monitor: RTL and testbench

TICK_RATE_MONITOR -- requirements
Module: tick_rate_monitor

---
 rtl/tick_rate_monitor.sv | 146 ++++++++++++++
 tb/tb_tick_rate_monitor.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/tick_rate_monitor.sv
// Tick rate monitor: divides an upstream tick stream by a captured ratio,
// produces a pulse, a square wave and a saturating pulse count, and flags missing ticks.
module tick_rate_monitor #(
  parameter int GAP_MAX = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       en,
  input  logic [3:0] div_n,
  output logic       tick_out,
  output logic       sq_out,
  output logic [7:0] tick_cnt,
  output logic       gap_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP_MAX - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] div_q;
  logic [3:0] div_q_nxt;
  logic [3:0] div_cnt;
  logic [3:0] div_cnt_nxt;
  logic [3:0] gap_cnt;
  logic [3:0] gap_cnt_nxt;
  logic       tick_out_nxt;
  logic       sq_out_nxt;
  logic [7:0] tick_cnt_nxt;
  logic       gap_err_nxt;
  logic [3:0] div_inc;
  logic [3:0] div_norm;

  // Saturating increment of the pulse counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A ratio of zero behaves as divide-by-one.
  function automatic logic [3:0] norm_div(input logic [3:0] v);
    return (v == 4'd0) ? 4'd1 : v;
  endfunction

  assign div_inc  = div_cnt + 4'd1;
  assign div_norm = norm_div(div_n);

  always_comb begin
    state_nxt    = state;
    div_q_nxt    = div_q;
    div_cnt_nxt  = div_cnt;
    gap_cnt_nxt  = gap_cnt;
    tick_out_nxt = 1'b0;
    sq_out_nxt   = sq_out;
    tick_cnt_nxt = tick_cnt;
    gap_err_nxt  = gap_err;

    if (!en) begin
      // Dropping enable wins over any coincident tick from every state.
      state_nxt   = IDLE;
      div_cnt_nxt = 4'd0;
      gap_cnt_nxt = 4'd0;
      sq_out_nxt  = 1'b0;
      gap_err_nxt = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          state_nxt   = ARMED;
          div_cnt_nxt = 4'd0;
          gap_cnt_nxt = 4'd0;
          sq_out_nxt  = 1'b0;
          gap_err_nxt = 1'b0;
        end
        ARMED: begin
          if (tick_in) begin
            state_nxt   = RUN;
            div_q_nxt   = div_norm;
            gap_cnt_nxt = 4'd0;
            if (div_norm == 4'd1) begin
              div_cnt_nxt  = 4'd0;
              tick_out_nxt = 1'b1;
              sq_out_nxt   = ~sq_out;
              tick_cnt_nxt = sat_inc8(tick_cnt);
            end else begin
              div_cnt_nxt = 4'd1;
            end
          end
        end
        RUN: begin
          if (tick_in) begin
            // A tick on the threshold cycle keeps the run alive.
            gap_cnt_nxt = 4'd0;
            if (div_inc == div_q) begin
              div_cnt_nxt  = 4'd0;
              tick_out_nxt = 1'b1;
              sq_out_nxt   = ~sq_out;
              tick_cnt_nxt = sat_inc8(tick_cnt);
            end else begin
              div_cnt_nxt = div_inc;
            end
          end else if (gap_cnt == GAP_LAST) begin
            state_nxt   = FAULT;
            gap_err_nxt = 1'b1;
          end else begin
            gap_cnt_nxt = gap_cnt + 4'd1;
          end
        end
        FAULT: begin
          gap_err_nxt = 1'b1;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      div_q    <= 4'd1;
      div_cnt  <= 4'd0;
      gap_cnt  <= 4'd0;
      tick_out <= 1'b0;
      sq_out   <= 1'b0;
      tick_cnt <= 8'd0;
      gap_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      div_q    <= div_q_nxt;
      div_cnt  <= div_cnt_nxt;
      gap_cnt  <= gap_cnt_nxt;
      tick_out <= tick_out_nxt;
      sq_out   <= sq_out_nxt;
      tick_cnt <= tick_cnt_nxt;
      gap_err  <= gap_err_nxt;
    end
  end

endmodule

// File: tb/tb_tick_rate_monitor.sv
// Directed bench for tick_rate_monitor with hand-computed expectations.
module tb_tick_rate_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_in;
  logic       en;
  logic [3:0] div_n;
  logic       tick_out;
  logic       sq_out;
  logic [7:0] tick_cnt;
  logic       gap_err;

  int n_cmp = 0;
  int n_err = 0;

  tick_rate_monitor #(.GAP_MAX(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .tick_in  (tick_in),
    .en       (en),
    .div_n    (div_n),
    .tick_out (tick_out),
    .sq_out   (sq_out),
    .tick_cnt (tick_cnt),
    .gap_err  (gap_err)
  );

  always #5 clk = ~clk;

  // Drive tick_in for one edge, then sample 1 time unit after that edge.
  task automatic cyc(input logic t);
    tick_in = t;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; en = 1'b0; div_n = 4'd0;
    cyc(1'b0); cyc(1'b1);
    n_cmp++; if (tick_out !== 1'b0) begin n_err++; $display("FAIL rst_tick_out got %b want 0", tick_out); end
    n_cmp++; if (sq_out !== 1'b0) begin n_err++; $display("FAIL rst_sq_out got %b want 0", sq_out); end
    n_cmp++; if (tick_cnt !== 8'd0) begin n_err++; $display("FAIL rst_tick_cnt got %0d want 0", tick_cnt); end
    n_cmp++; if (gap_err !== 1'b0) begin n_err++; $display("FAIL rst_gap_err got %b want 0", gap_err); end
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(i[0]);
      n_cmp++;
      if ({tick_out, sq_out, tick_cnt, gap_err} !== 11'd0) begin
        n_err++;
        $display("FAIL idle_ignore i=%0d got %b/%b/%0d/%b want all 0", i, tick_out, sq_out, tick_cnt, gap_err);
      end
    end
  endtask

  task automatic test_div2;
    en = 1'b1; div_n = 4'd2;
    cyc(1'b0);
    for (int j = 1; j <= 10; j++) begin
      cyc(1'b1);
      if (j == 1) div_n = 4'd5;
      n_cmp++; if (tick_out !== ((j % 2) == 0)) begin n_err++; $display("FAIL div2_tick_out j=%0d got %b want %b", j, tick_out, (j % 2) == 0); end
      n_cmp++; if (sq_out !== (((j / 2) % 2) == 1)) begin n_err++; $display("FAIL div2_sq j=%0d got %b want %b", j, sq_out, ((j / 2) % 2) == 1); end
      n_cmp++; if (tick_cnt !== 8'(j / 2)) begin n_err++; $display("FAIL div2_cnt j=%0d got %0d want %0d", j, tick_cnt, j / 2); end
      cyc(1'b0);
      n_cmp++; if (tick_out !== 1'b0) begin n_err++; $display("FAIL div2_gap_pulse j=%0d got %b want 0", j, tick_out); end
      cyc(1'b0);
    end
    en = 1'b0;
    cyc(1'b1);
    n_cmp++; if (tick_out !== 1'b0) begin n_err++; $display("FAIL div2_off_pulse got %b want 0", tick_out); end
    n_cmp++; if (sq_out !== 1'b0) begin n_err++; $display("FAIL div2_off_sq got %b want 0", sq_out); end
    n_cmp++; if (tick_cnt !== 8'd5) begin n_err++; $display("FAIL div2_cnt_kept got %0d want 5", tick_cnt); end
  endtask

  task automatic test_div0;
    int exp_cnt;
    en = 1'b1; div_n = 4'd0;
    cyc(1'b0);
    for (int j = 1; j <= 300; j++) begin
      cyc(1'b1);
      exp_cnt = (5 + j > 255) ? 255 : 5 + j;
      n_cmp++; if (tick_out !== 1'b1) begin n_err++; $display("FAIL div0_tick_out j=%0d got %b want 1", j, tick_out); end
      n_cmp++; if (tick_cnt !== 8'(exp_cnt)) begin n_err++; $display("FAIL div0_cnt j=%0d got %0d want %0d", j, tick_cnt, exp_cnt); end
      n_cmp++; if (sq_out !== ((j % 2) == 1)) begin n_err++; $display("FAIL div0_sq j=%0d got %b want %b", j, sq_out, (j % 2) == 1); end
      cyc(1'b0);
      cyc(1'b0);
    end
    en = 1'b0;
    cyc(1'b0);
  endtask

  task automatic test_gap;
    reset = 1'b1; en = 1'b0; cyc(1'b0);
    reset = 1'b0; en = 1'b1; div_n = 4'd1;
    cyc(1'b0);
    cyc(1'b1);
    n_cmp++; if (tick_out !== 1'b1 || tick_cnt !== 8'd1) begin n_err++; $display("FAIL gap_first got %b/%0d want 1/1", tick_out, tick_cnt); end
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b0);
      n_cmp++; if (gap_err !== 1'b0) begin n_err++; $display("FAIL gap_pre i=%0d got %b want 0", i, gap_err); end
    end
    cyc(1'b1);
    n_cmp++; if (gap_err !== 1'b0 || tick_out !== 1'b1 || tick_cnt !== 8'd2) begin n_err++; $display("FAIL gap_tick_wins got %b/%b/%0d want 0/1/2", gap_err, tick_out, tick_cnt); end
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0);
      n_cmp++; if (gap_err !== (i == 4)) begin n_err++; $display("FAIL gap_edge i=%0d got %b want %b", i, gap_err, i == 4); end
    end
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1);
      n_cmp++; if (tick_out !== 1'b0 || tick_cnt !== 8'd2 || gap_err !== 1'b1) begin n_err++; $display("FAIL fault_hold got %b/%0d/%b want 0/2/1", tick_out, tick_cnt, gap_err); end
    end
    en = 1'b0;
    cyc(1'b0);
    n_cmp++; if (gap_err !== 1'b0) begin n_err++; $display("FAIL fault_clear got %b want 0", gap_err); end
    en = 1'b1;
    cyc(1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0);
      n_cmp++; if (gap_err !== 1'b0) begin n_err++; $display("FAIL armed_wait i=%0d got %b want 0", i, gap_err); end
    end
    cyc(1'b1);
    n_cmp++; if (tick_out !== 1'b1 || tick_cnt !== 8'd3) begin n_err++; $display("FAIL rearm_tick got %b/%0d want 1/3", tick_out, tick_cnt); end
    for (int i = 0; i < 4; i++) cyc(1'b0);
    n_cmp++; if (gap_err !== 1'b1) begin n_err++; $display("FAIL refault got %b want 1", gap_err); end
    reset = 1'b1;
    cyc(1'b1);
    n_cmp++; if (gap_err !== 1'b0 || tick_cnt !== 8'd0 || tick_out !== 1'b0) begin n_err++; $display("FAIL rst_in_fault got %b/%0d/%b want 0/0/0", gap_err, tick_cnt, tick_out); end
    reset = 1'b0;
  endtask

  task automatic test_en_drop;
    reset = 1'b1; en = 1'b0; cyc(1'b0);
    reset = 1'b0; en = 1'b1; div_n = 4'd2;
    cyc(1'b0);
    cyc(1'b1); cyc(1'b0);
    cyc(1'b1);
    n_cmp++; if (tick_out !== 1'b1 || sq_out !== 1'b1 || tick_cnt !== 8'd1) begin n_err++; $display("FAIL endrop_setup got %b/%b/%0d want 1/1/1", tick_out, sq_out, tick_cnt); end
    cyc(1'b0);
    cyc(1'b1);
    cyc(1'b0);
    en = 1'b0;
    cyc(1'b1);
    n_cmp++; if (tick_out !== 1'b0) begin n_err++; $display("FAIL endrop_pulse got %b want 0", tick_out); end
    n_cmp++; if (tick_cnt !== 8'd1) begin n_err++; $display("FAIL endrop_cnt got %0d want 1", tick_cnt); end
    n_cmp++; if (sq_out !== 1'b0) begin n_err++; $display("FAIL endrop_sq got %b want 0", sq_out); end
  endtask

  task automatic test_reset_mid_run;
    reset = 1'b1; en = 1'b0; cyc(1'b0);
    reset = 1'b0; en = 1'b1; div_n = 4'd1;
    cyc(1'b0);
    for (int i = 0; i < 7; i++) begin cyc(1'b1); cyc(1'b0); end
    n_cmp++; if (tick_cnt !== 8'd7 || sq_out !== 1'b1) begin n_err++; $display("FAIL midrun_setup got %0d/%b want 7/1", tick_cnt, sq_out); end
    reset = 1'b1;
    cyc(1'b1);
    n_cmp++; if (tick_cnt !== 8'd0 || sq_out !== 1'b0 || tick_out !== 1'b0) begin n_err++; $display("FAIL midrun_rst got %0d/%b/%b want 0/0/0", tick_cnt, sq_out, tick_out); end
    reset = 1'b0;
    cyc(1'b0);
    cyc(1'b1);
    n_cmp++; if (tick_out !== 1'b1 || tick_cnt !== 8'd1 || sq_out !== 1'b1) begin n_err++; $display("FAIL midrun_rearm got %b/%0d/%b want 1/1/1", tick_out, tick_cnt, sq_out); end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; tick_in = 1'b0; div_n = 4'd0;
    test_reset;
    test_div2;
    test_div0;
    test_gap;
    test_en_drop;
    test_reset_mid_run;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
